// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator for the single-port word memory bus.
// Byte/half/word requests become word-aligned accesses with lane masks.
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wstrobe,
  output logic        mem_rstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic          we_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [CW-1:0] cnt;

  logic          misal;
  logic          acc;
  logic          st;
  logic [1:0]    off;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ext;
  logic [31:0]   lane_wd;
  logic [3:0]    lane_m;

  // Illegal size is folded into the misalignment flag.
  always_comb begin
    unique case (req_size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = req_addr[0];
      2'b10:   misal = |req_addr[1:0];
      default: misal = 1'b1;
    endcase
  end

  assign off    = addr_q[1:0];
  assign lane_b = mem_rdata[{off, 3'b000} +: 8];
  assign lane_h = mem_rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    lane_wd = wdata_q;
    lane_m  = 4'b1111;
    unique case (size_q)
      2'b00: begin
        lane_wd = {4{wdata_q[7:0]}};
        lane_m  = 4'b0001 << off;
      end
      2'b01: begin
        lane_wd = {2{wdata_q[15:0]}};
        lane_m  = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (size_q)
      2'b00:   ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: ext = mem_rdata;
    endcase
  end

  assign acc         = (state == S_ACCESS);
  assign st          = acc & we_q;
  assign mem_addr    = acc ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata   = st ? lane_wd : '0;
  assign mem_wmask   = st ? lane_m : '0;
  assign mem_wstrobe = st;
  assign mem_rstrobe = acc & ~we_q;

  assign req_ready   = (state == S_IDLE);
  assign resp_valid  = (state == S_RESP);
  assign resp_err    = resp_valid & err_q;
  assign resp_rdata  = resp_valid ? rdata_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= misal;
            cnt     <= '0;
            state   <= misal ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_done) begin
            rdata_q <= we_q ? '0 : ext;
            state   <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and random requests against a byte-level memory model.
// The bench owns a bus memory and an independent reference copy.
module tb_mem_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wstrobe;
  logic        mem_rstrobe;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        done_en = 1'b1;

  logic [31:0] bus_mem [64];
  logic [31:0] ref_mem [64];

  int checks = 0;
  int errors = 0;

  mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_wstrobe(mem_wstrobe),
    .mem_rstrobe(mem_rstrobe), .mem_rdata(mem_rdata),
    .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  assign mem_done  = done_en;
  assign mem_rdata = bus_mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) bus_mem[i] <= '0;
    end else if (mem_wstrobe && mem_done) begin
      for (int l = 0; l < 4; l++)
        if (mem_wmask[l])
          bus_mem[mem_addr[7:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz,
                        input logic un, input logic [31:0] a,
                        input logic [31:0] wd);
    int o, idx, nb, lat, nstb, bad_lane, bad_dir;
    logic bad, got, o_err;
    logic [31:0] exp_rd, exp_wd, w, v, o_rd;
    logic [3:0] exp_m;
    o   = int'(a % 4);
    idx = int'((a % 256) / 4);
    bad = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
          (sz == 2'd2 && o != 0);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    w   = ref_mem[idx];
    exp_rd = '0;
    exp_m  = '0;
    exp_wd = wd;
    if (!we) begin
      if (nb == 1) begin
        v = (w >> (8 * o)) & 32'hFF;
        exp_rd = (!un && v >= 128) ? v - 256 : v;
      end else if (nb == 2) begin
        v = (w >> (16 * (o / 2))) & 32'hFFFF;
        exp_rd = (!un && v >= 32768) ? v - 65536 : v;
      end else begin
        exp_rd = w;
      end
    end else begin
      exp_m  = 4'((2 ** nb - 1) << o);
      if (nb == 1) exp_wd = (wd & 32'hFF) * 32'h01010101;
      if (nb == 2) exp_wd = (wd & 32'hFFFF) * 32'h00010001;
    end
    if (bad || !done_en) exp_rd = '0;

    @(negedge clk);
    chk("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_unsigned = un; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nstb = 0; bad_lane = 0; bad_dir = 0;
    got = 1'b0; o_err = 1'b0; o_rd = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_wstrobe || mem_rstrobe) begin
        nstb++;
        if (mem_wstrobe !== we || mem_rstrobe !== !we) bad_dir++;
        if (mem_addr !== (a & ~32'd3)) bad_lane++;
        if (mem_wmask !== exp_m) bad_lane++;
        if (we && mem_wdata !== exp_wd) bad_lane++;
      end
      if (resp_valid) begin
        got = 1'b1; o_err = resp_err; o_rd = resp_rdata;
      end
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), bad ? 32'd1 : done_en ? 32'd2 : 32'(TO + 1));
    chk("strobe_cycles", 32'(nstb), bad ? 32'd0 : done_en ? 32'd1 : 32'(TO));
    chk("strobe_dir", 32'(bad_dir), 32'd0);
    chk("bus_lanes", 32'(bad_lane), 32'd0);
    chk("resp_err", 32'(o_err), 32'(bad || !done_en));
    chk("resp_rdata", o_rd, exp_rd);
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
    if (we && !bad && done_en)
      for (int k = 0; k < nb; k++) begin
        v = (wd >> (8 * k)) & 32'hFF;
        ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * (o + k)))) |
                       (v << (8 * (o + k)));
      end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0] sz;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_strobes", 32'({mem_wstrobe, mem_rstrobe}), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wmask", 32'(mem_wmask), 32'd0);
    rst_n = 1'b1;

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h03, 32'h5555);
    do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0);

    done_en = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hAA);
    done_en = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Reset in the middle of an access: drop it silently.
    done_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rstrobe", 32'(mem_rstrobe), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_strobes", 32'({mem_wstrobe, mem_rstrobe}), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd1);
    chk("mid_valid", 32'(resp_valid), 32'd0);
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_resp", 32'(resp_valid), 32'd0);
    end

    for (int n = 0; n < 60; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & ~32'd1;
        if (sz == 2'd2) a = a & ~32'd3;
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
